adder_seq_ctrl: RTL and testbench
=================================

Name: adder_seq_ctrl

Overview:
Sequencer that performs NBYTES-wide add/subtract by time-multiplexing one adder_byte instance, one byte per clock, LSB first. A registered carry links each byte to the next. It sits between the ALU operand registers and the result bus. Valid/ready handshakes on both sides let the ALU issue and retire multi-byte operations.

Parameters:
NBYTES, 4, number of bytes per operand; legal range 2..16.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation request.
in_ready  output  1  controller can accept an operation.
op_a  input  8*NBYTES  operand A.
op_b  input  8*NBYTES  operand B.
op_sub  input  1  0 = A+B, 1 = A-B.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
result  output  8*NBYTES  sum or difference.
carry_out  output  1  final carry; for subtraction 1 = no borrow.
overflow  output  1  signed (two's-complement) overflow.

Behaviour:
- Reset is asynchronous and active-low: clk plus rst_n. Asserting rst_n low forces:
  - state IDLE, byte index 0, carry register 0;
  - in_ready=1 on release (low while in reset is acceptable), out_valid=0;
  - result=0, carry_out=0, overflow=0.
- Reset mid-operation aborts the operation. Partial results are discarded and nothing is retained.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - Accept occurs at an edge where in_valid && in_ready.
  - On accept, capture op_a and op_b into internal registers. For op_sub=1, capture ~op_b.
  - Set the carry register to op_sub. This gives two's-complement subtract.
  - Clear byte index and result; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, feed byte[idx] of A and B', plus the carry register, to adder_byte.
  - At the edge, write the sum to result[8*idx +: 8] and the adder carry_out to the carry register, then increment idx.
  - At the edge where idx==NBYTES-1, also do the following and go to DONE:
    - carry_out <= adder carry;
    - overflow <= (A_msb == B'_msb) && (sum_msb != A_msb).
- DONE:
  - out_valid=1.
  - result, carry_out and overflow are held stable until out_ready is high at an edge. At that edge go to IDLE with out_valid=0.
  - No same-cycle re-accept: in_ready rises the cycle after retire.
- Latency: out_valid rises exactly NBYTES clock edges after the accepting edge. Minimum issue interval is NBYTES+2 cycles.
- in_valid and operand changes while not in IDLE are ignored. Captured operands are not affected.
- Outputs result, carry_out and overflow keep their last values in IDLE until the next operation's RUN overwrites them. Consumers may only sample them while out_valid=1.
- The index counter width is clog2(NBYTES). It never wraps past NBYTES-1.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Add with byte carry ripple: A=0x000000FF, B=0x00000001, sub=0.
  - Required: result=0x00000100, carry_out=0, overflow=0.
  - out_valid high exactly 4 edges after accept.
- Full-width wrap: A=0xFFFFFFFF, B=0x00000001.
  - Required: result=0x00000000, carry_out=1, overflow=0.
- Subtract with borrow: A=0x00000005, B=0x00000007, sub=1.
  - Required: result=0xFFFFFFFE, carry_out=0, overflow=0.
  - Companion case: A=7, B=5 -> result=0x00000002, carry_out=1.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, add.
  - Required: result=0x80000000, overflow=1.
  - Companion case: A=0x80000000, B=1, sub -> result=0x7FFFFFFF, overflow=1.
- Backpressure and ignored requests:
  - Hold out_ready=0 for 10 cycles in DONE while toggling in_valid and operands.
  - Required: result and flags stable, in_ready=0.
  - After out_ready pulse: IDLE, then in_ready=1 the next cycle.
- Reset mid-RUN: drop rst_n asynchronously after 2 RUN cycles.
  - Required: immediately out_valid=0 and result=0.
  - After release: in_ready=1, and a new op A=3, B=4 yields 0x00000007.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Multi-byte add/subtract sequencer: one shared byte adder walks the operands
// LSB first, linking bytes through a registered carry, with valid/ready on both sides.

module adder_byte (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
    end

    assign sum  = full[7:0];
    assign cout = full[8];
endmodule

module adder_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                op_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] result,
    output logic                carry_out,
    output logic                overflow
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = $clog2(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry_reg;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    result_reg;
    logic            carry_out_reg;
    logic            overflow_reg;

    logic            accept;
    logic            run_step;
    logic            last_byte;
    logic            retire;

    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      sum_byte;
    logic            carry_byte;

    // Byte lane select: idx concatenated with 3 zeros is the bit offset of the lane.
    always_comb begin
        a_byte = a_reg[{idx, 3'b000} +: 8];
        b_byte = b_reg[{idx, 3'b000} +: 8];
    end

    adder_byte u_adder_byte (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_reg),
        .sum  (sum_byte),
        .cout (carry_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        run_step   = 1'b0;
        last_byte  = 1'b0;
        retire     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                run_step = 1'b1;
                if (idx == LAST_IDX) begin
                    last_byte  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B at capture and seed the carry with op_sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            idx           <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (accept) begin
            a_reg      <= op_a;
            b_reg      <= op_sub ? ~op_b : op_b;
            carry_reg  <= op_sub;
            idx        <= '0;
            result_reg <= '0;
        end else if (run_step) begin
            result_reg[{idx, 3'b000} +: 8] <= sum_byte;
            carry_reg                      <= carry_byte;
            if (last_byte) begin
                idx           <= '0;
                carry_out_reg <= carry_byte;
                overflow_reg  <= (a_reg[W-1] == b_reg[W-1]) && (sum_byte[7] != a_reg[W-1]);
            end else begin
                idx <= idx + IDXW'(1);
            end
        end
    end

    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;

    logic unused_retire;
    assign unused_retire = retire;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: directed cases, random ops against an
// arithmetic reference model, backpressure and asynchronous reset mid-operation.

module tb_adder_seq_ctrl;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic for the sum, compare for borrow,
    // sign rules for two's-complement overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0]   wide;
        logic [W-1:0] res;
        logic         cy;
        logic         ov;
        if (sub) begin
            res = a - b;
            cy  = (a >= b);
            ov  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            res  = wide[W-1:0];
            cy   = wide[W];
            ov   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
        end
        return {ov, cy, res};
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 4 * NBYTES) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_in_ready", {63'b0, in_ready}, 64'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int hold);
        logic [W+1:0] exp;
        logic [W-1:0] res_seen;
        logic         cy_seen;
        logic         ov_seen;
        int           lat;
        exp = model(a, b, sub);
        wait_idle();
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("busy_in_ready", {63'b0, in_ready}, 64'd0);
        // Scramble inputs during RUN; out_ready high here must be harmless.
        lat = 0;
        while (!out_valid && lat < 3 * NBYTES) begin
            in_valid  = 1'($urandom);
            op_a      = $urandom;
            op_b      = $urandom;
            op_sub    = 1'($urandom);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
        check_eq("latency", 64'(lat), 64'(NBYTES));
        check_eq("result", 64'(result), 64'(exp[W-1:0]));
        check_eq("carry_out", {63'b0, carry_out}, {63'b0, exp[W]});
        check_eq("overflow", {63'b0, overflow}, {63'b0, exp[W+1]});
        res_seen = result;
        cy_seen  = carry_out;
        ov_seen  = overflow;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            op_a     = $urandom;
            op_b     = $urandom;
            op_sub   = 1'($urandom);
            @(posedge clk);
            #1;
            check_eq("hold_valid", {63'b0, out_valid}, 64'd1);
            check_eq("hold_in_ready", {63'b0, in_ready}, 64'd0);
            check_eq("hold_result", 64'({ov_seen, cy_seen, res_seen}), 64'({overflow, carry_out, result}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("retire_valid", {63'b0, out_valid}, 64'd0);
        check_eq("retire_in_ready", {63'b0, in_ready}, 64'd1);
        check_eq("idle_result_kept", 64'(result), 64'(exp[W-1:0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        #23;
        check_eq("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_flags", {62'b0, carry_out, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", {63'b0, in_ready}, 64'd1);

        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        check_eq("ripple_literal", 64'(result), 64'h0000_0100);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        check_eq("wrap_carry_literal", {63'b0, carry_out}, 64'd1);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
        check_eq("borrow_literal", 64'(result), 64'hFFFF_FFFE);
        do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 0);
        check_eq("noborrow_literal", {63'b0, carry_out}, 64'd1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        check_eq("add_ovf_literal", {63'b0, overflow}, 64'd1);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 10);
        check_eq("sub_ovf_literal", 64'(result), 64'h7FFF_FFFF);

        for (int k = 0; k < 24; k++) begin
            do_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset two RUN cycles into an operation.
        wait_idle();
        op_a     = 32'h1234_5678;
        op_b     = 32'h1111_1111;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", {63'b0, out_valid}, 64'd0);
        check_eq("abort_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("abort_in_ready", {63'b0, in_ready}, 64'd1);
        do_op(32'h0000_0003, 32'h0000_0004, 1'b0, 0);
        check_eq("after_reset_literal", 64'(result), 64'h0000_0007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
